// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer/occupancy controller driving an external 1-cycle-read memory
// Optional feature: FIFO_CTRL_ERR_STICKY_EN (sticky overflow/underflow with err_clr_i)
module fifo_ctrl #(
  parameter int ADDR_LEN     = 8,
  parameter int AFULL_THRESH = (1 << ADDR_LEN) - 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_req_i,
  input  logic                rd_req_i,
`ifdef FIFO_CTRL_ERR_STICKY_EN
  input  logic                err_clr_i,
`endif
  output logic                mem_wen_o,
  output logic [ADDR_LEN-1:0] mem_waddr_o,
  output logic                mem_ren_o,
  output logic [ADDR_LEN-1:0] mem_raddr_o,
  output logic                rvalid_o,
  output logic [ADDR_LEN:0]   count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                afull_o,
  output logic                overflow_o,
  output logic                underflow_o
);

  localparam logic [ADDR_LEN:0] DEPTH   = {1'b1, {ADDR_LEN{1'b0}}};
  localparam logic [ADDR_LEN:0] AFULL_C = (ADDR_LEN + 1)'(AFULL_THRESH);

  logic [ADDR_LEN:0] wr_ptr;
  logic [ADDR_LEN:0] rd_ptr;
  logic              ovf_evt;
  logic              unf_evt;

  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == DEPTH);
  assign afull_o = (count_o >= AFULL_C);

  // Gated by rst_n so requests raised during reset never reach the memory.
  assign mem_wen_o   = rst_n & wr_req_i & ~full_o;
  assign mem_ren_o   = rst_n & rd_req_i & ~empty_o;
  assign mem_waddr_o = wr_ptr[ADDR_LEN-1:0];
  assign mem_raddr_o = rd_ptr[ADDR_LEN-1:0];

  assign ovf_evt = wr_req_i & full_o;
  assign unf_evt = rd_req_i & empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_o     <= '0;
      rvalid_o    <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (mem_wen_o) wr_ptr <= wr_ptr + 1'b1;
      if (mem_ren_o) rd_ptr <= rd_ptr + 1'b1;
      case ({mem_wen_o, mem_ren_o})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
      rvalid_o <= mem_ren_o;
`ifdef FIFO_CTRL_ERR_STICKY_EN
      // A new error on the same edge as a clear keeps the flag set.
      overflow_o  <= ovf_evt | (overflow_o  & ~err_clr_i);
      underflow_o <= unf_evt | (underflow_o & ~err_clr_i);
`else
      overflow_o  <= ovf_evt;
      underflow_o <= unf_evt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl (ADDR_LEN=8)
module tb_fifo_ctrl;

  localparam int AL    = 8;
  localparam int DEPTH = 256;
  localparam int AFT   = DEPTH - 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_req_i;
  logic          rd_req_i;
  logic          err_clr_i;
  logic          mem_wen_o;
  logic [AL-1:0] mem_waddr_o;
  logic          mem_ren_o;
  logic [AL-1:0] mem_raddr_o;
  logic          rvalid_o;
  logic [AL:0]   count_o;
  logic          full_o;
  logic          empty_o;
  logic          afull_o;
  logic          overflow_o;
  logic          underflow_o;

  int n_cmp  = 0;
  int n_fail = 0;

  int m_w, m_r, m_cnt;
  bit m_ovf, m_unf;

  fifo_ctrl #(.ADDR_LEN(AL), .AFULL_THRESH(AFT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req_i    (wr_req_i),
    .rd_req_i    (rd_req_i),
`ifdef FIFO_CTRL_ERR_STICKY_EN
    .err_clr_i   (err_clr_i),
`endif
    .mem_wen_o   (mem_wen_o),
    .mem_waddr_o (mem_waddr_o),
    .mem_ren_o   (mem_ren_o),
    .mem_raddr_o (mem_raddr_o),
    .rvalid_o    (rvalid_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .afull_o     (afull_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of traffic checked against the bench's own occupancy model.
  task automatic cyc(input bit wr, input bit rd);
    bit exp_wen, exp_ren, ovf, unf;
    wr_req_i = wr;
    rd_req_i = rd;
    #1;
    exp_wen = wr && (m_cnt != DEPTH);
    exp_ren = rd && (m_cnt != 0);
    ovf     = wr && (m_cnt == DEPTH);
    unf     = rd && (m_cnt == 0);
    chk("mem_wen", {31'd0, mem_wen_o}, {31'd0, exp_wen});
    chk("mem_ren", {31'd0, mem_ren_o}, {31'd0, exp_ren});
    if (exp_wen) chk("mem_waddr", {24'd0, mem_waddr_o}, m_w % DEPTH);
    if (exp_ren) chk("mem_raddr", {24'd0, mem_raddr_o}, m_r % DEPTH);
    @(posedge clk);
    #1;
    if (exp_wen) m_w = (m_w + 1) % (2 * DEPTH);
    if (exp_ren) m_r = (m_r + 1) % (2 * DEPTH);
    m_cnt = m_cnt + int'(exp_wen) - int'(exp_ren);
`ifdef FIFO_CTRL_ERR_STICKY_EN
    m_ovf = m_ovf | ovf;
    m_unf = m_unf | unf;
`else
    m_ovf = ovf;
    m_unf = unf;
`endif
    chk("count", {23'd0, count_o}, m_cnt);
    chk("empty", {31'd0, empty_o}, {31'd0, m_cnt == 0});
    chk("full", {31'd0, full_o}, {31'd0, m_cnt == DEPTH});
    chk("afull", {31'd0, afull_o}, {31'd0, m_cnt >= AFT});
    chk("rvalid", {31'd0, rvalid_o}, {31'd0, exp_ren});
    chk("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
    chk("underflow", {31'd0, underflow_o}, {31'd0, m_unf});
  endtask

  task automatic do_reset(input bit wr, input bit rd);
    rst_n    = 1'b0;
    wr_req_i = wr;
    rd_req_i = rd;
    #1;
    chk("rst_wen", {31'd0, mem_wen_o}, 0);
    chk("rst_ren", {31'd0, mem_ren_o}, 0);
    step();
    m_w = 0; m_r = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
    chk("rst_count", {23'd0, count_o}, 0);
    chk("rst_empty", {31'd0, empty_o}, 1);
    chk("rst_full", {31'd0, full_o}, 0);
    chk("rst_afull", {31'd0, afull_o}, 0);
    chk("rst_rvalid", {31'd0, rvalid_o}, 0);
    chk("rst_ovf", {31'd0, overflow_o}, 0);
    chk("rst_unf", {31'd0, underflow_o}, 0);
    rst_n    = 1'b1;
    wr_req_i = 1'b0;
    rd_req_i = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_req_i  = 1'b0;
    rd_req_i  = 1'b0;
    err_clr_i = 1'b0;
    step();
    // Requests held during reset must be ignored.
    do_reset(1'b1, 1'b1);

    // Underflow on an empty FIFO, then the flag's following cycle.
    cyc(1'b0, 1'b1);
    chk("unf_after_empty_read", {31'd0, underflow_o}, 1);
    cyc(1'b0, 1'b0);

    // Fill to DEPTH; afull boundary 251->252 covered by the model.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0);
    chk("fill_count", {23'd0, count_o}, 256);
    chk("fill_full", {31'd0, full_o}, 1);
    chk("fill_afull", {31'd0, afull_o}, 1);

    // Write while full: rejected, overflow raised.
    cyc(1'b1, 1'b0);
    chk("ovf_count", {23'd0, count_o}, 256);
    chk("ovf_flag", {31'd0, overflow_o}, 1);

    // Both requests at full: read wins, count 255.
    cyc(1'b1, 1'b1);
    chk("both_full_count", {23'd0, count_o}, 255);

    // Drain to 5, both requests keep count at 5.
    for (int i = 0; i < 250; i++) cyc(1'b0, 1'b1);
    chk("drain_count", {23'd0, count_o}, 5);
    cyc(1'b1, 1'b1);
    chk("both_5_count", {23'd0, count_o}, 5);

    // Drain to 0, both requests at empty: write wins, count 1.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("both_empty_count", {23'd0, count_o}, 1);
    chk("both_empty_unf", {31'd0, underflow_o}, 1);

    // Fresh start: write A, read at address 0, rvalid one cycle later.
    do_reset(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    wr_req_i = 1'b0;
    rd_req_i = 1'b1;
    #1;
    chk("rd_a_ren", {31'd0, mem_ren_o}, 1);
    chk("rd_a_raddr", {24'd0, mem_raddr_o}, 0);
    step();
    rd_req_i = 1'b0;
    m_r = 1; m_cnt = 0;
    chk("rd_a_rvalid", {31'd0, rvalid_o}, 1);
    chk("rd_a_count", {23'd0, count_o}, 0);
    chk("rd_a_empty", {31'd0, empty_o}, 1);
    step();
    chk("rd_a_rvalid_drop", {31'd0, rvalid_o}, 0);

    // 300 interleaved write/read pairs wrap both pointers past 255.
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
    end
    chk("wrap_wptr", {24'd0, mem_waddr_o}, 301 % DEPTH);
    chk("wrap_rptr", {24'd0, mem_raddr_o}, 301 % DEPTH);

    // Reset at count 10 with a read in flight.
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0);
    chk("pre_rst_count", {23'd0, count_o}, 11);
    cyc(1'b0, 1'b1);
    chk("pre_rst_count10", {23'd0, count_o}, 10);
    do_reset(1'b0, 1'b1);
    cyc(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter: ADDR_LEN, default 8, memory address width; DEPTH = 2^ADDR_LEN entries.
REQ-002 Parameter: AFULL_THRESH, default DEPTH-4, occupancy at which afull_o asserts; legal range 1..DEPTH.
REQ-003 Clock and reset SHALL be one clock and a synchronous active-low reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 wr_req_i  in  1  write request.
REQ-007 rd_req_i  in  1  read request.
REQ-008 mem_wen_o  out  1  memory write enable; drives the memory's wen_i.
REQ-009 mem_waddr_o  out  ADDR_LEN  memory write address.
REQ-010 mem_ren_o  out  1  memory read enable; drives the memory's ren_i.
REQ-011 mem_raddr_o  out  ADDR_LEN  memory read address.
REQ-012 rvalid_o  out  1  memory rdata valid this cycle.
REQ-013 count_o  out  ADDR_LEN+1  current occupancy, 0..DEPTH.
REQ-014 full_o, empty_o, afull_o  out  1 each  status flags.
REQ-015 overflow_o, underflow_o  out  1 each  error indications.
REQ-016 err_clr_i  in  1  error clear; present only with FIFO_CTRL_ERR_STICKY_EN.

Function
REQ-017 Write and read pointers SHALL be ADDR_LEN+1 bits; mem_waddr_o and mem_raddr_o are their low ADDR_LEN bits.
REQ-018 A write SHALL be accepted when wr_req_i=1 and full_o=0; mem_wen_o = wr_req_i & ~full_o (combinational); the write pointer increments on the same edge.
REQ-019 A read SHALL be accepted when rd_req_i=1 and empty_o=0; mem_ren_o = rd_req_i & ~empty_o (combinational); the read pointer increments on the same edge.
REQ-020 rvalid_o SHALL be registered mem_ren_o, asserting exactly one cycle after an accepted read, matching the memory's 1-cycle registered read.
REQ-021 count_o SHALL be a register: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
REQ-022 Flags SHALL decode from registered count_o: empty_o = (count==0), full_o = (count==DEPTH), afull_o = (count>=AFULL_THRESH).
REQ-023 Full with both requests: read accepted, write rejected; count becomes DEPTH-1.
REQ-024 Empty with both requests: write accepted, read rejected; count becomes 1; no read-during-write bypass.
REQ-025 Pointers SHALL wrap modulo 2^(ADDR_LEN+1) with no gap; address DEPTH-1 is followed by 0.
REQ-026 overflow_o SHALL flag wr_req_i=1 while full_o=1; underflow_o SHALL flag rd_req_i=1 while empty_o=1; rejected requests never alter pointers or count.

Reset
REQ-027 While rst_n=0 at a clk edge: pointers=0, count_o=0, rvalid_o=0, overflow_o=0, underflow_o=0; hence empty_o=1, full_o=0, afull_o=0, mem_wen_o=0, mem_ren_o=0.
REQ-028 Reset mid-operation SHALL discard all occupancy; memory contents are not cleared, and an in-flight rvalid_o is dropped.
REQ-029 Requests SHALL be ignored in every cycle rst_n=0.

Configuration
REQ-030 Macro FIFO_CTRL_ERR_STICKY_EN defined: overflow_o/underflow_o are sticky, set on the error cycle's edge, held until err_clr_i=1 or reset; set wins over a same-cycle clear.
REQ-031 Macro undefined: err_clr_i is absent; overflow_o/underflow_o are registered one-cycle pulses, asserted the cycle after each error.

Verification
REQ-032 Reset, then 256 writes (ADDR_LEN=8) -> count_o=256, full_o=1, afull_o=1 from count 252, mem_waddr_o 0..255.
REQ-033 Full plus wr_req_i -> mem_wen_o=0, count unchanged, overflow_o=1 (pulse or sticky per macro).
REQ-034 Write A, then read next cycle -> mem_ren_o=1 at raddr 0, rvalid_o=1 one cycle later, count 1->0, empty_o=1.
REQ-035 Simultaneous requests at count 0, 5, 256 -> count becomes 1, 5, 255 respectively.
REQ-036 Run 300 writes/reads interleaved -> pointers wrap 255->0, no lost or duplicated addresses.
REQ-037 Assert rst_n=0 at count 10 -> next cycle count_o=0, empty_o=1, rvalid_o=0, error flags 0.
